// File: rtl/uart_pkg.sv
// Shared types and constants for the button-triggered UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 10416;
    localparam int unsigned FRAME_BITS           = 10;
    // One start bit and one stop bit frame the payload.
    localparam int unsigned DATA_BITS            = FRAME_BITS - 2;

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector for the debounced button level.
// Ports:
//   clk_100MHz - system clock
//   reset      - synchronous active-high reset
//   btn_in     - debounced button level
//   press_c    - combinational one-shot, high in the first cycle btn_in is seen high
module btn_edge_detect (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic btn_in,
    output logic press_c
);

    logic btn_prev_q;

    // Resets high so a button held through reset is not seen as a press.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            btn_prev_q <= 1'b1;
        end else begin
            btn_prev_q <= btn_in;
        end
    end

    assign press_c = btn_in & ~btn_prev_q;

endmodule

// File: rtl/btn_uart_tx.sv
// Sends the switch byte as one UART 8N1 frame per button press, with a
// one-entry pending slot for a press that arrives while a frame is in flight.
// Ports:
//   clk_100MHz - system clock
//   reset      - synchronous active-high reset
//   btn_in     - debounced button level
//   data_in    - switch byte, captured on the press cycle
//   tx         - serial line, idle high
//   tx_busy    - high while a frame is on the line
//   tx_done    - one-cycle pulse after each stop bit completes
//   drop_pulse - one-cycle pulse when a press is discarded
module btn_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned CNT_W        = 14
) (
    input  logic                 clk_100MHz,
    input  logic                 reset,
    input  logic                 btn_in,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 drop_pulse
);

    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    tx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] pend_q, pend_d;
    logic                 pend_valid_q, pend_valid_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 drop_q, drop_d;
    logic                 press_c;
    logic                 bit_end_c;
    logic                 stop_end_c;

    btn_edge_detect u_edge (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .btn_in     (btn_in),
        .press_c    (press_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            drop_q       <= drop_d;
        end
    end

    assign bit_end_c  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign stop_end_c = (state_q == STOP) && bit_end_c;

    // Next-state, datapath and registered-output logic. tx_d is the line
    // value for the coming cycle, so a press shows on tx one cycle later.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        tx_d         = tx_q;
        done_d       = 1'b0;
        drop_d       = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (press_c) begin
                    state_d = START;
                    shift_d = data_in;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (bit_end_c) begin
                    state_d   = DATA;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    cnt_d = '0;
                    if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                        tx_d      = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end_c) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    // Pending byte wins over a fresh press; start bit follows with no gap.
                    if (pend_valid_q) begin
                        state_d      = START;
                        shift_d      = pend_q;
                        pend_valid_d = 1'b0;
                        tx_d         = 1'b0;
                    end else if (press_c) begin
                        state_d = START;
                        shift_d = data_in;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase

        // Press while busy: fill the pending slot, or drop if it is full.
        // At end of stop the slot is being emptied, so a press refills it.
        if (press_c && (state_q != IDLE)) begin
            if (stop_end_c) begin
                if (pend_valid_q) begin
                    pend_d       = data_in;
                    pend_valid_d = 1'b1;
                end
            end else if (!pend_valid_q) begin
                pend_d       = data_in;
                pend_valid_d = 1'b1;
            end else begin
                drop_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    assign tx         = tx_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;
    assign drop_pulse = drop_q;

endmodule
